// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, FSM state encoding and bit-period helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int  DEF_WIDTH_WORD    = 8;
    localparam int  DEF_BAUD_RATE     = 9600;
    localparam int  DEF_CANT_BIT_STOP = 2;
    localparam real DEF_FREC_CLK_MHZ  = 100.0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

    // int' cast rounds to nearest, e.g. 100 MHz / 9600 baud -> 10417
    function automatic int calc_clks_per_bit(input real frec_clk_mhz, input int baud_rate);
        return int'(frec_clk_mhz * 1.0e6 / real'(baud_rate));
    endfunction

endpackage

// File: rtl/transmisor_uart_if.sv
// Handshake bundle between the ALU/interface control (master) and the UART transmitter (slave).
interface transmisor_uart_if
    import uart_pkg::*;
#(
    parameter int WIDTH_WORD = DEF_WIDTH_WORD
);
    logic                  i_tx_start;
    logic [WIDTH_WORD-1:0] i_data_in;
    logic                  o_tx;
    logic                  o_tx_busy;
    logic                  o_tx_done;

    modport master (
        output i_tx_start,
        output i_data_in,
        input  o_tx,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_tx_start,
        input  i_data_in,
        output o_tx,
        output o_tx_busy,
        output o_tx_done
    );
endinterface

// File: rtl/baud_tick_gen_tx.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, o_tick marks the wrap cycle.
module baud_tick_gen_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_reg <= '0;
        end else if (!i_enable || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign o_tick = i_enable && (cnt_reg == CNT_LAST);
endmodule

// File: rtl/transmisor_uart.sv
// UART transmitter: start bit, WIDTH_WORD data bits LSB first, CANT_BIT_STOP stop bits, no parity.
// All outputs are registered so the serial line never glitches.
module transmisor_uart
    import uart_pkg::*;
#(
    parameter int  WIDTH_WORD    = DEF_WIDTH_WORD,
    parameter real FREC_CLK_MHZ  = DEF_FREC_CLK_MHZ,
    parameter int  BAUD_RATE     = DEF_BAUD_RATE,
    parameter int  CANT_BIT_STOP = DEF_CANT_BIT_STOP
) (
    input  logic              i_clock,
    input  logic              i_reset,
    transmisor_uart_if.slave  bus
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(FREC_CLK_MHZ, BAUD_RATE);
    localparam int BIT_W        = (WIDTH_WORD > 1) ? $clog2(WIDTH_WORD) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH_WORD - 1);
    localparam logic             STOP_LAST = 1'(CANT_BIT_STOP - 1);

    tx_state_t             state_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic                  stop_cnt_reg;
    logic [WIDTH_WORD-1:0] shift_reg;
    logic [WIDTH_WORD-1:0] shift_next;
    logic                  tick;

    // Timer runs only inside a frame, so it is already cleared when a start is accepted
    baud_tick_gen_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_enable(state_reg != IDLE),
        .o_tick  (tick)
    );

    assign shift_next = shift_reg >> 1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    done_reg <= 1'b0;
                    if (bus.i_tx_start) begin
                        shift_reg    <= bus.i_data_in;
                        bit_cnt_reg  <= '0;
                        stop_cnt_reg <= 1'b0;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= shift_next;
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        if (bit_cnt_reg == BIT_LAST) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg <= shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_tx      = tx_reg;
    assign bus.o_tx_busy = busy_reg;
    assign bus.o_tx_done = done_reg;
endmodule

// File: tb/tb_transmisor_uart.sv
// Directed bench for transmisor_uart at 10 clocks per bit, with 2-stop and 1-stop instances.
module tb_transmisor_uart;
    logic clk;
    logic rst_n;
    bit   sel;   // 0: two-stop-bit DUT, 1: one-stop-bit DUT

    int n_tests = 0;
    int n_fail  = 0;

    transmisor_uart_if #(.WIDTH_WORD(8)) bus2 ();
    transmisor_uart_if #(.WIDTH_WORD(8)) bus1 ();

    transmisor_uart #(
        .WIDTH_WORD(8), .FREC_CLK_MHZ(1.0), .BAUD_RATE(100000), .CANT_BIT_STOP(2)
    ) dut2 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus2.slave)
    );

    transmisor_uart #(
        .WIDTH_WORD(8), .FREC_CLK_MHZ(1.0), .BAUD_RATE(100000), .CANT_BIT_STOP(1)
    ) dut1 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic obs_tx();
        return sel ? bus1.o_tx : bus2.o_tx;
    endfunction
    function automatic logic obs_busy();
        return sel ? bus1.o_tx_busy : bus2.o_tx_busy;
    endfunction
    function automatic logic obs_done();
        return sel ? bus1.o_tx_done : bus2.o_tx_done;
    endfunction

    task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic start, input logic [7:0] d);
        if (sel) begin
            bus1.i_tx_start = start;
            bus1.i_data_in  = d;
        end else begin
            bus2.i_tx_start = start;
            bus2.i_data_in  = d;
        end
    endtask

    // Strobe is driven at a negedge before calling; acceptance edge is cycle 0.
    // Ends at the negedge of the done cycle, leaving the caller free to strobe again.
    task automatic run_frame(input logic [7:0] d, input int nstop, input int inject, input string tag);
        int total;
        logic exp_tx;
        total = (1 + 8 + nstop) * 10;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, ~d);
            if (k <= 10)      exp_tx = 1'b0;
            else if (k <= 90) exp_tx = d[(k - 11) / 10];
            else              exp_tx = 1'b1;
            check({tag, "_tx"},   k, obs_tx(),   exp_tx);
            check({tag, "_busy"}, k, obs_busy(), 1'b1);
            check({tag, "_done"}, k, obs_done(), 1'b0);
            if (inject != 0 && k == inject)     drive(1'b1, 8'hFF);
            if (inject != 0 && k == inject + 1) drive(1'b0, 8'hFF);
        end
        @(negedge clk);
        check({tag, "_done_end"}, total + 1, obs_done(), 1'b1);
        check({tag, "_busy_end"}, total + 1, obs_busy(), 1'b0);
        check({tag, "_tx_end"},   total + 1, obs_tx(),   1'b1);
        $display("[TB] frame %s data=%02h stop=%0d done at cycle %0d", tag, d, nstop, total + 1);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_tx"},   k, obs_tx(),   1'b1);
            check({tag, "_busy"}, k, obs_busy(), 1'b0);
            check({tag, "_done"}, k, obs_done(), 1'b0);
        end
    endtask

    initial begin
        sel             = 1'b0;
        rst_n           = 1'b0;
        bus2.i_tx_start = 1'b0;
        bus2.i_data_in  = 8'h00;
        bus1.i_tx_start = 1'b0;
        bus1.i_data_in  = 8'h00;

        // Reset held, then a long quiet idle
        idle_cycles(20, "reset_hold");
        rst_n = 1'b1;
        idle_cycles(200, "idle_after_reset");
        $display("[TB] reset/idle: 220 quiet cycles");

        // Single frame
        @(negedge clk); drive(1'b1, 8'hA5);
        run_frame(8'hA5, 2, 0, "single_a5");
        idle_cycles(5, "single_a5_after");

        // Start pulse during a frame must be ignored
        @(negedge clk); drive(1'b1, 8'h0F);
        run_frame(8'h0F, 2, 40, "ignore_0f");
        idle_cycles(5, "ignore_0f_after");

        // Back-to-back: second strobe lands in the done cycle
        @(negedge clk); drive(1'b1, 8'h80);
        run_frame(8'h80, 2, 0, "b2b_80");
        drive(1'b1, 8'h01);
        run_frame(8'h01, 2, 0, "b2b_01");
        idle_cycles(5, "b2b_after");

        // Reset in the middle of an all-zero frame
        @(negedge clk); drive(1'b1, 8'h00);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 8'hFF);
        end
        check("midreset_pre_tx", 50, obs_tx(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_async_tx",   50, obs_tx(),   1'b1);
        check("midreset_async_busy", 50, obs_busy(), 1'b0);
        check("midreset_async_done", 50, obs_done(), 1'b0);
        idle_cycles(3, "midreset_hold");
        rst_n = 1'b1;
        idle_cycles(120, "midreset_after");
        $display("[TB] mid-frame reset: line idle, no done pulse");
        @(negedge clk); drive(1'b1, 8'h3C);
        run_frame(8'h3C, 2, 0, "post_reset_3c");
        idle_cycles(5, "post_reset_3c_after");

        // One-stop-bit instance
        sel = 1'b1;
        idle_cycles(3, "stop1_idle");
        @(negedge clk); drive(1'b1, 8'hC3);
        run_frame(8'hC3, 1, 0, "stop1_c3");
        idle_cycles(5, "stop1_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/transmisor_uart.md
Name: transmisor_uart

Overview:
- UART serial transmitter: the other end of the link whose receiver the top samples on uart_txd_in. Sends ALU results back to the PC on uart_rxd_out.
- Takes one parallel word with a start strobe and serialises it as start bit, WIDTH_WORD data bits LSB first, then CANT_BIT_STOP stop bits. No parity.
- Sits between the ALU/interface control and the top-level uart_rxd_out pin.

Parameters:
- WIDTH_WORD, 8: data bits per frame.
- FREC_CLK_MHZ, 100.0: clock frequency in MHz.
- BAUD_RATE, 9600: bits per second.
- CANT_BIT_STOP, 2: number of stop bits, legal values 1 or 2.
- CLKS_PER_BIT, derived localparam: round(FREC_CLK_MHZ*1e6/BAUD_RATE), which is 10417 at the defaults.

Ports:
- i_clock, in, 1: system clock; all logic runs on the rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_tx_start, in, 1: one-cycle start strobe, sampled only in IDLE.
- i_data_in, in, WIDTH_WORD: word to send, latched in the cycle i_tx_start is accepted.
- o_tx, out, 1: serial line, idles at 1. Registered output.
- o_tx_busy, out, 1: high while a frame is in progress.
- o_tx_done, out, 1: one-cycle pulse at the end of a frame.

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, bit counter=0, tick counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately. o_tx returns to 1 with no glitch low, and no o_tx_done pulse is generated.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - o_tx=1.
  - If i_tx_start=1: latch i_data_in into the shift register, clear the tick counter, go to START.
  - i_tx_start while not in IDLE is ignored; there is no queueing.
- START: o_tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after acceptance.
- DATA:
  - o_tx = shift register bit 0. On each bit-period end, shift right and increment the bit counter.
  - After WIDTH_WORD bit periods, go to STOP.
- STOP: o_tx=1 for CANT_BIT_STOP*CLKS_PER_BIT cycles, then go to IDLE.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps to 0. Each wrap ends one bit period.
- Frame length: (1+WIDTH_WORD+CANT_BIT_STOP)*CLKS_PER_BIT cycles of non-idle line, measured from the first low cycle to the last stop-bit cycle.
- o_tx_busy:
  - Goes to 1 in the cycle after acceptance.
  - Goes to 0 in the cycle o_tx_done is high, i.e. the first IDLE cycle.
- o_tx_done: high for exactly one cycle, the first IDLE cycle after the last stop bit.
- Back-to-back frames: i_tx_start is accepted in the same cycle o_tx_done is high. The next start bit then begins one cycle later, so the line shows an inter-frame idle of 1 clock beyond the stop bits.
- i_data_in changes after acceptance do not affect the frame in flight.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - the CLKS_PER_BIT computation function;
  - the default WIDTH_WORD, BAUD_RATE and CANT_BIT_STOP values, shared with the receiver.
- One sub-module, baud_tick_gen_tx:
  - parameter CLKS_PER_BIT; inputs i_clock, i_reset, i_enable;
  - output o_tick, one cycle at count wrap;
  - counter clears whenever i_enable=0.

Test Plan (bench overrides FREC_CLK_MHZ=1.0, BAUD_RATE=100000, giving CLKS_PER_BIT=10):
- Idle after reset: hold i_reset=0 for 20 cycles, then release -> o_tx=1, o_tx_busy=0, o_tx_done=0 throughout; no transitions for 200 cycles.
- Single frame: pulse i_tx_start with i_data_in=8'hA5 ->
  - o_tx low for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high 20 cycles;
  - o_tx_done pulses at cycle 111 after the strobe;
  - o_tx_busy high for 110 cycles.
- Start ignored while busy: send 8'h0F, then pulse i_tx_start with 8'hFF at cycle 40 -> the frame serialises 8'h0F unchanged and only one o_tx_done occurs.
- Back-to-back: assert i_tx_start with 8'h01 in the o_tx_done cycle of a preceding 8'h80 frame -> the second start bit begins exactly 1 cycle after o_tx_done, and a line receiver decodes 0x80 then 0x01.
- Reset mid-frame: assert i_reset=0 at cycle 50 of an 8'h00 frame -> o_tx=1 asynchronously, o_tx_busy=0, no o_tx_done; a new frame with 8'h3C after release is correct.
- CANT_BIT_STOP=1 variant: send 8'hC3 -> stop period is 10 cycles and o_tx_done arrives at cycle 101.
